de2_key_debouncer: RTL and testbench
====================================

// Module: de2_key_debouncer
// PURPOSE
//  Per-key synchroniser and debouncer for the active-low DE2 push-buttons.
//  Sits directly upstream of the keys PIO: key_db drives the PIO in_port, so
//  the PIO's falling-edge capture fires exactly once per clean key press.
//  Also provides one-cycle press/release strobes for local hardware consumers.
// PARAMETERS
//  N_KEYS          4        number of independent keys
//  DEBOUNCE_CYCLES 1000000  stable clocks required before key_db changes (20 ms @ 50 MHz); >=2
//  REPEAT_DELAY    25000000 held clocks before first auto-repeat (KEY_AUTOREPEAT_EN only); >=2
//  REPEAT_PERIOD   5000000  held clocks between auto-repeats (KEY_AUTOREPEAT_EN only); >=2
//  Counter width CW = $clog2(max(DEBOUNCE_CYCLES,REPEAT_DELAY,REPEAT_PERIOD)+1), one counter per key.
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  reset_n      in   1       synchronous, active-low reset
//  key_raw      in   N_KEYS  asynchronous button inputs, 0 = pressed
//  key_db       out  N_KEYS  debounced level, 0 = pressed, registered
//  key_press    out  N_KEYS  1-cycle strobe, asserted in the first cycle key_db[i]==0
//  key_release  out  N_KEYS  1-cycle strobe, asserted in the first cycle key_db[i]==1
// BEHAVIOUR
//  Reset (reset_n==0 at a clk edge): sync FFs <= all 1; key_db <= all 1;
//   key_press, key_release <= 0; all FSMs <= UP; all counters <= 0.
//   Reset mid-debounce or mid-repeat abandons the operation; no strobe is produced.
//  Sync: key_s = 2-FF synchroniser of key_raw, per bit, no reset-free FFs.
//  Per-key FSM, stable value sv (1 in UP/UP_WAIT... see states), counter cnt:
//   UP        (sv=1): key_s==0 -> DN_WAIT, cnt<=1; else hold, cnt<=0.
//   DN_WAIT        : key_s==1 -> UP, cnt<=0 (bounce rejected);
//                    cnt==DEBOUNCE_CYCLES -> DOWN, key_db<=0, key_press<=1, cnt<=0;
//                    else cnt<=cnt+1.
//   DOWN      (sv=0): key_s==1 -> UP_WAIT, cnt<=1; else hold (repeat logic below).
//   UP_WAIT        : key_s==0 -> DOWN, cnt<=0; cnt==DEBOUNCE_CYCLES -> UP,
//                    key_db<=1, key_release<=1, cnt<=0; else cnt<=cnt+1.
//  Latency: key_raw change sampled at edge r -> key_db changes at edge r+2+DEBOUNCE_CYCLES,
//   provided key_raw holds the new level throughout. Any contrary key_s sample restarts it.
//  Strobes are high for exactly one cycle, never both in the same cycle for one key.
//  Keys are fully independent; simultaneous presses produce simultaneous strobes.
//  Counter never wraps: it is cleared on every state transition and saturates logic
//   by construction (max compare value < 2^CW).
// CONFIGURATION
//  KEY_AUTOREPEAT_EN defined: in DOWN with key_s==0, cnt counts held clocks. When
//   cnt reaches REPEAT_DELAY (first) or REPEAT_PERIOD (subsequent): key_db[i]<=1 for
//   exactly one cycle (state REP_GAP), cnt<=0; next cycle key_db[i]<=0 and key_press<=1,
//   back to DOWN. This gives the PIO a fresh falling edge per repeat. No key_release
//   strobe for repeat gaps. key_s==1 seen in REP_GAP -> UP_WAIT, cnt<=1, key_db stays 1.
//   A one-bit per-key flag selects DELAY vs PERIOD; cleared on leaving DOWN/REP_GAP.
//  KEY_AUTOREPEAT_EN undefined: DOWN holds cnt at 0; key_db stays 0 for the whole
//   hold; REPEAT_* parameters are unused; no REP_GAP state exists.
// TESTING (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4, N_KEYS=4)
//  1 Reset: key_raw=4'h0, reset_n low 3 clks -> key_db=4'hF, key_press=key_release=0.
//  2 Clean press: key_raw[0] 1->0 sampled at edge r -> key_db[0]=0 and key_press[0]=1
//    after edge r+6, key_press[0]=0 after r+7; other bits unchanged.
//  3 Bounce: key_raw[1] 0 for 3 clks, 1 for 1 clk, 0 held -> exactly one key_press[1],
//    key_db[1] falls 6 edges after the final 1->0 sample; no release strobe.
//  4 Simultaneous: key_raw 4'hF->4'h5 in one cycle -> key_press=4'hA in a single cycle;
//    then 4'hF -> key_release=4'hA once, key_db=4'hF.
//  5 Reset mid-debounce: press key 2, assert reset_n at 2nd post-sync edge -> no strobe,
//    key_db[2]=1; after release of reset with key still held, full 6-edge debounce reruns.
//  6 Auto-repeat (macro on): hold key 3 for 40 clks -> key_press[3] at debounce, then
//    1-cycle key_db[3]=1 gaps after 8 held clks and every 5 clks after (4 + gap), one
//    key_press[3] per gap; macro off -> single key_press[3], key_db[3]=0 throughout.

Source files
------------

// File: rtl/de2_key_debouncer.sv
// Per-key 2-FF synchroniser and debouncer for the active-low DE2 push-buttons,
// with one-cycle press/release strobes. Optional auto-repeat: define KEY_AUTOREPEAT_EN.
module de2_key_debouncer #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_db,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CNT = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] DB_LIM = CW'(DEBOUNCE_CYCLES);
`ifdef KEY_AUTOREPEAT_EN
  // cnt is 0 on entry to DOWN, so LIM-1 fires after exactly LIM held clocks.
  localparam logic [CW-1:0] DLY_LIM = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LIM = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {UP, DN_WAIT, DOWN, UP_WAIT, REP_GAP} state_t;
`else
  typedef enum logic [1:0] {UP, DN_WAIT, DOWN, UP_WAIT} state_t;
`endif

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] key_s;

  // NOTE: synchroniser FFs reset to the idle (released) level so a reset never
  // looks like a press; sequential state always uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '1;
      key_s <= '1;
    end else begin
      sync1 <= key_raw;
      key_s <= sync1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    state_t        state;
    logic [CW-1:0] cnt;
    logic          db_q;
    logic          press_q;
    logic          rel_q;
`ifdef KEY_AUTOREPEAT_EN
    logic          rep_flag;
`endif

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state   <= UP;
        cnt     <= '0;
        db_q    <= 1'b1;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rep_flag <= 1'b0;
`endif
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        case (state)
          UP: begin
            if (!key_s[i]) begin
              state <= DN_WAIT;
              cnt   <= CW'(1);
            end else begin
              cnt <= '0;
            end
          end
          DN_WAIT: begin
            if (key_s[i]) begin
              state <= UP;
              cnt   <= '0;
            end else if (cnt == DB_LIM) begin
              state   <= DOWN;
              db_q    <= 1'b0;
              press_q <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DOWN: begin
            if (key_s[i]) begin
              state <= UP_WAIT;
              cnt   <= CW'(1);
`ifdef KEY_AUTOREPEAT_EN
              rep_flag <= 1'b0;
`endif
            end else begin
`ifdef KEY_AUTOREPEAT_EN
              if (cnt == (rep_flag ? PER_LIM : DLY_LIM)) begin
                state    <= REP_GAP;
                db_q     <= 1'b1;
                cnt      <= '0;
                rep_flag <= 1'b1;
              end else begin
                cnt <= cnt + CW'(1);
              end
`else
              cnt <= '0;
`endif
            end
          end
          UP_WAIT: begin
            if (!key_s[i]) begin
              state <= DOWN;
              cnt   <= '0;
            end else if (cnt == DB_LIM) begin
              state <= UP;
              db_q  <= 1'b1;
              rel_q <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
`ifdef KEY_AUTOREPEAT_EN
          // One-cycle high gap gives the PIO a fresh falling edge per repeat.
          REP_GAP: begin
            if (key_s[i]) begin
              state    <= UP_WAIT;
              cnt      <= CW'(1);
              rep_flag <= 1'b0;
            end else begin
              state   <= DOWN;
              db_q    <= 1'b0;
              press_q <= 1'b1;
              cnt     <= '0;
            end
          end
`endif
          default: begin
            state <= UP;
            cnt   <= '0;
            db_q  <= 1'b1;
          end
        endcase
      end
    end

    assign key_db[i]      = db_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = rel_q;
  end

endmodule

// File: tb/tb_de2_key_debouncer.sv
// Directed self-checking bench for de2_key_debouncer (DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=8, REPEAT_PERIOD=4); follows KEY_AUTOREPEAT_EN if defined.
module tb_de2_key_debouncer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] key_raw = 4'hF;
  logic [3:0] key_db;
  logic [3:0] key_press;
  logic [3:0] key_release;

  int n_pass  = 0;
  int n_total = 0;
  int press_cnt [4];
  int rel_cnt   [4];
  int both_cnt  = 0;

  de2_key_debouncer #(
    .N_KEYS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_raw(key_raw),
    .key_db(key_db), .key_press(key_press), .key_release(key_release)
  );

  always #5 clk = ~clk;

  // Strobes last a full cycle, so one sample per falling edge counts each once.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (key_press[i])   press_cnt[i]++;
      if (key_release[i]) rel_cnt[i]++;
      if (key_press[i] && key_release[i]) both_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
  endtask

  task automatic test_reset();
    key_raw = 4'h0;
    reset_n = 1'b0;
    step(3);
    n_total++; if (key_db !== 4'hF) $display("FAIL reset_db: got %h want %h", key_db, 4'hF); else n_pass++;
    n_total++; if (key_press !== 4'h0) $display("FAIL reset_press: got %h want %h", key_press, 4'h0); else n_pass++;
    n_total++; if (key_release !== 4'h0) $display("FAIL reset_release: got %h want %h", key_release, 4'h0); else n_pass++;
    key_raw = 4'hF;
    step(1);
    reset_n = 1'b1;
    step(3);
    clear_counts();
  endtask

  task automatic test_clean_press();
    clear_counts();
    key_raw[0] = 1'b0;           // sampled at edge r
    step(6);                     // after r+5
    n_total++; if (key_db !== 4'hF) $display("FAIL press_early_db: got %h want %h", key_db, 4'hF); else n_pass++;
    step(1);                     // after r+6
    n_total++; if (key_db !== 4'hE) $display("FAIL press_db: got %h want %h", key_db, 4'hE); else n_pass++;
    n_total++; if (key_press !== 4'h1) $display("FAIL press_strobe: got %h want %h", key_press, 4'h1); else n_pass++;
    step(1);                     // after r+7
    n_total++; if (key_press !== 4'h0) $display("FAIL press_strobe_end: got %h want %h", key_press, 4'h0); else n_pass++;
    n_total++; if (key_db !== 4'hE) $display("FAIL press_hold_db: got %h want %h", key_db, 4'hE); else n_pass++;
    key_raw[0] = 1'b1;
    step(8);
    n_total++; if (key_db !== 4'hF) $display("FAIL release_db: got %h want %h", key_db, 4'hF); else n_pass++;
    n_total++; if (rel_cnt[0] !== 1) $display("FAIL release_count: got %0d want 1", rel_cnt[0]); else n_pass++;
    n_total++; if (press_cnt[0] !== 1) $display("FAIL press_count: got %0d want 1", press_cnt[0]); else n_pass++;
  endtask

  task automatic test_bounce();
    clear_counts();
    key_raw[1] = 1'b0;
    step(3);
    key_raw[1] = 1'b1;
    step(1);
    key_raw[1] = 1'b0;           // final 1->0 sampled at edge r
    step(6);
    n_total++; if (key_db !== 4'hF) $display("FAIL bounce_early_db: got %h want %h", key_db, 4'hF); else n_pass++;
    step(1);
    n_total++; if (key_db !== 4'hD) $display("FAIL bounce_db: got %h want %h", key_db, 4'hD); else n_pass++;
    step(3);
    n_total++; if (press_cnt[1] !== 1) $display("FAIL bounce_press_count: got %0d want 1", press_cnt[1]); else n_pass++;
    n_total++; if (rel_cnt[1] !== 0) $display("FAIL bounce_release_count: got %0d want 0", rel_cnt[1]); else n_pass++;
    key_raw[1] = 1'b1;
    step(8);
    n_total++; if (key_db !== 4'hF) $display("FAIL bounce_release_db: got %h want %h", key_db, 4'hF); else n_pass++;
  endtask

  task automatic test_simultaneous();
    clear_counts();
    key_raw = 4'h5;
    step(6);
    n_total++; if (key_press !== 4'h0) $display("FAIL simul_press_early: got %h want %h", key_press, 4'h0); else n_pass++;
    step(1);
    n_total++; if (key_press !== 4'hA) $display("FAIL simul_press: got %h want %h", key_press, 4'hA); else n_pass++;
    n_total++; if (key_db !== 4'h5) $display("FAIL simul_db: got %h want %h", key_db, 4'h5); else n_pass++;
    step(1);
    n_total++; if (key_press !== 4'h0) $display("FAIL simul_press_end: got %h want %h", key_press, 4'h0); else n_pass++;
    key_raw = 4'hF;
    step(6);
    n_total++; if (key_release !== 4'h0) $display("FAIL simul_rel_early: got %h want %h", key_release, 4'h0); else n_pass++;
    step(1);
    n_total++; if (key_release !== 4'hA) $display("FAIL simul_release: got %h want %h", key_release, 4'hA); else n_pass++;
    n_total++; if (key_db !== 4'hF) $display("FAIL simul_release_db: got %h want %h", key_db, 4'hF); else n_pass++;
    step(1);
    n_total++; if (key_release !== 4'h0) $display("FAIL simul_rel_end: got %h want %h", key_release, 4'h0); else n_pass++;
    n_total++; if (rel_cnt[1] + rel_cnt[3] !== 2) $display("FAIL simul_rel_count: got %0d want 2", rel_cnt[1] + rel_cnt[3]); else n_pass++;
  endtask

  task automatic test_reset_mid_debounce();
    clear_counts();
    key_raw[2] = 1'b0;           // sampled at edge r
    step(3);                     // after r+2
    reset_n = 1'b0;              // sampled at r+3
    step(1);
    n_total++; if (key_db !== 4'hF) $display("FAIL midrst_db: got %h want %h", key_db, 4'hF); else n_pass++;
    reset_n = 1'b1;              // key still held; next edge is r'
    step(6);
    n_total++; if (key_db !== 4'hF) $display("FAIL midrst_early_db: got %h want %h", key_db, 4'hF); else n_pass++;
    n_total++; if (press_cnt[2] !== 0) $display("FAIL midrst_no_strobe: got %0d want 0", press_cnt[2]); else n_pass++;
    step(1);
    n_total++; if (key_db !== 4'hB) $display("FAIL midrst_db_rerun: got %h want %h", key_db, 4'hB); else n_pass++;
    n_total++; if (key_press !== 4'h4) $display("FAIL midrst_press: got %h want %h", key_press, 4'h4); else n_pass++;
    key_raw[2] = 1'b1;
    step(8);
    n_total++; if (key_db !== 4'hF) $display("FAIL midrst_release_db: got %h want %h", key_db, 4'hF); else n_pass++;
  endtask

  task automatic test_autorepeat();
    logic exp_db;
    logic exp_press;
    int   exp_presses;
    int   bad;
    clear_counts();
    bad = 0;
    key_raw[3] = 1'b0;           // sampled at edge r (k=0)
    for (int k = 0; k < 40; k++) begin
      step(1);                   // after edge r+k
`ifdef KEY_AUTOREPEAT_EN
      exp_db    = (k < 6) || (k >= 14 && (k - 14) % 5 == 0);
      exp_press = (k == 6) || (k >= 15 && (k - 15) % 5 == 0);
`else
      exp_db    = (k < 6);
      exp_press = (k == 6);
`endif
      if (key_db[3] !== exp_db || key_press[3] !== exp_press) begin
        bad++;
        $display("FAIL repeat_trace k=%0d: got db=%b press=%b want db=%b press=%b",
                 k, key_db[3], key_press[3], exp_db, exp_press);
      end
      if (k == 37) key_raw[3] = 1'b1;
    end
    n_total++; if (bad !== 0) $display("FAIL repeat_trace_total: got %0d bad cycles want 0", bad); else n_pass++;
    step(8);
`ifdef KEY_AUTOREPEAT_EN
    exp_presses = 6;
`else
    exp_presses = 1;
`endif
    n_total++; if (press_cnt[3] !== exp_presses) $display("FAIL repeat_press_count: got %0d want %0d", press_cnt[3], exp_presses); else n_pass++;
    n_total++; if (rel_cnt[3] !== 1) $display("FAIL repeat_release_count: got %0d want 1", rel_cnt[3]); else n_pass++;
    n_total++; if (key_db !== 4'hF) $display("FAIL repeat_final_db: got %h want %h", key_db, 4'hF); else n_pass++;
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
    test_autorepeat();
    n_total++; if (both_cnt !== 0) $display("FAIL both_strobes: got %0d want 0", both_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
